reg_bus_mux: RTL and testbench
==============================

Name: reg_bus_mux

Overview:
- Parametrised successor to the processor datapath bus multiplexer.
- Holds N_REGS general registers.
- Drives a registered shared bus from one of G, DIN or a register, with a select priority that is defined for every input combination.
- Detects illegal multi-source selects, and supports one-hot or binary register select.
- Sits between the control FSM and the ALU/G register.

Parameters:
WIDTH, 16, data/bus width in bits
N_REGS, 8, number of general registers (>=2)
SEL_ENCODED, 0, 0 = register source from one-hot Rout; 1 = from binary RSel qualified by RSelEn
IDX_W, clog2(N_REGS), width of RSel (derived, not overridden)

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  synchronous, active-high reset
DIN  in  WIDTH  external data input
G  in  WIDTH  ALU result register
Gout  in  1  select G onto bus
DINout  in  1  select DIN onto bus
Rout  in  N_REGS  one-hot register source select (ignored when SEL_ENCODED=1)
RSel  in  IDX_W  binary register index (ignored when SEL_ENCODED=0)
RSelEn  in  1  qualifies RSel (ignored when SEL_ENCODED=0)
Rin  in  N_REGS  per-register load enable, data taken from BusWires
ClrErr  in  1  clears SelErr
BusWires  out  WIDTH  registered bus value
BusValid  out  1  bus was loaded on the last edge
SelErr  out  1  sticky illegal-select flag
RegFlat  out  N_REGS*WIDTH  register contents, reg i at bits [i*WIDTH +: WIDTH]

Behaviour:
- Reset (sync, highest priority): all registers, BusWires, BusValid and SelErr go to 0.
- Source requests: Gout, DINout, and the register request.
  - Register request when SEL_ENCODED=0: any Rout bit set.
  - Register request when SEL_ENCODED=1: RSelEn=1 and RSel < N_REGS.
- Priority: G > DIN > register.
  - With several Rout bits set, the lowest index wins.
- Bus update, 1-cycle latency: at the edge, BusWires <= the winning source and BusValid <= 1.
- No request: BusWires holds its value and BusValid <= 0.
- Illegal select: SelErr <= 1 at the edge when any of the following holds:
  - more than one of {Gout, DINout, register request} is active;
  - more than one Rout bit is set (SEL_ENCODED=0);
  - RSelEn=1 with RSel >= N_REGS (SEL_ENCODED=1).
- Bus behaviour on illegal select: in the first two cases the bus still loads the priority winner. In the out-of-range case with no other source active, the bus holds and BusValid <= 0.
- SelErr is sticky. ClrErr clears it at the edge; a new error in the same cycle takes priority and SelErr stays 1.
- Register write: at the edge, reg[i] <= BusWires (the pre-edge value) for every i with Rin[i]=1. Multiple Rin bits set is legal (broadcast).
- Read/write same register in one cycle: the bus captures the old reg[i], and reg[i] loads the old BusWires.
- RegFlat is combinational from the register state, with no extra latency.
- Encoded mode ignores Rout entirely; one-hot mode ignores RSel/RSelEn.
- Reset asserted mid-sequence discards any pending selection. The first post-reset edge with Reset low behaves normally.

Decomposition:
- Shared package:
  - WIDTH default;
  - clog2 function;
  - source encoding localparams SRC_NONE/SRC_G/SRC_DIN/SRC_REG;
  - a popcount function used for error detection.
- One sub-module, bus_src_decode (combinational). It takes Gout/DINout/Rout/RSel/RSelEn and outputs the source code, register index, load flag and error flag.
- The top level holds the register array, bus register, BusValid and SelErr.

Test Plan:
- Reset, then DINout=1 with DIN=16'hA5A5 -> next edge BusWires=A5A5, BusValid=1. Following idle cycle -> BusWires holds A5A5, BusValid=0.
- Load chain: DINout with DIN=16'h1234, next cycle Rin=8'b0000_0100 -> reg2=1234. Then Rout=8'b0000_0100 -> BusWires=1234.
- Conflict: Gout=1, DINout=1, G=16'h00FF, DIN=16'hFF00 -> BusWires=00FF, SelErr=1. SelErr stays 1 after idle. ClrErr=1 -> 0. ClrErr plus new conflict -> stays 1.
- Same-cycle read/write: reg3=0x0003, BusWires=0x0099, Rout=bit3, Rin=bit3 -> BusWires=0x0003, reg3=0x0099.
- SEL_ENCODED=1, N_REGS=6: RSel=5 with RSelEn -> reg5 on bus. RSel=7 with RSelEn -> bus holds, BusValid=0, SelErr=1.
- Reset asserted while DINout=1 -> BusWires=0, BusValid=0, all registers 0 after that edge.

Source files
------------

// File: rtl/reg_bus_mux_pkg.sv
// reg_bus_mux_pkg: shared widths, source codes and helper functions for the bus mux.
package reg_bus_mux_pkg;

   localparam int DEF_WIDTH = 16;

   localparam logic [1:0] SRC_NONE = 2'd0;
   localparam logic [1:0] SRC_G    = 2'd1;
   localparam logic [1:0] SRC_DIN  = 2'd2;
   localparam logic [1:0] SRC_REG  = 2'd3;

   // Index width for n entries; never below 1 so ports stay legal.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic int popcount(input logic [63:0] v);
      int c;
      c = 0;
      for (int i = 0; i < 64; i++) c += int'(v[i]);
      return c;
   endfunction

endpackage

// File: rtl/reg_bus_mux_bus_src_decode.sv
// bus_src_decode: resolves bus source by priority G > DIN > register and flags illegal selects.
module bus_src_decode
   import reg_bus_mux_pkg::*;
#(
   parameter int N_REGS      = 8,
   parameter bit SEL_ENCODED = 1'b0,
   parameter int IDX_W       = clog2(N_REGS)
) (
   input  logic              gout,
   input  logic              dinout,
   input  logic [N_REGS-1:0] rout,
   input  logic [IDX_W-1:0]  rsel,
   input  logic              rsel_en,
   output logic [1:0]        src,
   output logic [IDX_W-1:0]  idx,
   output logic              load,
   output logic              err
);

   localparam logic [IDX_W:0] N_LIM = (IDX_W + 1)'(N_REGS);

   logic             in_range;
   logic             reg_req;
   logic [IDX_W-1:0] oh_idx;

   always_comb begin
      in_range = {1'b0, rsel} < N_LIM;
      reg_req  = SEL_ENCODED ? (rsel_en && in_range) : |rout;
      // Descending scan so the lowest set Rout bit is the one left standing.
      oh_idx = '0;
      for (int i = N_REGS - 1; i >= 0; i--)
         if (rout[i]) oh_idx = IDX_W'(i);
      idx  = SEL_ENCODED ? rsel : oh_idx;
      src  = gout ? SRC_G : dinout ? SRC_DIN : reg_req ? SRC_REG : SRC_NONE;
      load = src != SRC_NONE;
      err  = popcount(64'({gout, dinout, reg_req})) > 1
          || (!SEL_ENCODED && popcount(64'(rout)) > 1)
          || (SEL_ENCODED && rsel_en && !in_range);
   end

endmodule

// File: rtl/reg_bus_mux.sv
// reg_bus_mux: register file with a registered shared bus, priority source select and sticky select error.
module reg_bus_mux
   import reg_bus_mux_pkg::*;
#(
   parameter  int WIDTH       = DEF_WIDTH,
   parameter  int N_REGS      = 8,
   parameter  bit SEL_ENCODED = 1'b0,
   localparam int IDX_W       = clog2(N_REGS)
) (
   input  logic                    Clock,
   input  logic                    Reset,
   input  logic [WIDTH-1:0]        DIN,
   input  logic [WIDTH-1:0]        G,
   input  logic                    Gout,
   input  logic                    DINout,
   input  logic [N_REGS-1:0]       Rout,
   input  logic [IDX_W-1:0]        RSel,
   input  logic                    RSelEn,
   input  logic [N_REGS-1:0]       Rin,
   input  logic                    ClrErr,
   output logic [WIDTH-1:0]        BusWires,
   output logic                    BusValid,
   output logic                    SelErr,
   output logic [N_REGS*WIDTH-1:0] RegFlat
);

   logic [N_REGS-1:0][WIDTH-1:0] regs_q, regs_d;
   logic [WIDTH-1:0]             bus_q, bus_d;
   logic                         valid_q, valid_d;
   logic                         err_q, err_d;
   logic [1:0]                   src;
   logic [IDX_W-1:0]             idx;
   logic                         load;
   logic                         dec_err;

   bus_src_decode #(
      .N_REGS      (N_REGS),
      .SEL_ENCODED (SEL_ENCODED),
      .IDX_W       (IDX_W)
   ) u_dec (
      .gout    (Gout),
      .dinout  (DINout),
      .rout    (Rout),
      .rsel    (RSel),
      .rsel_en (RSelEn),
      .src     (src),
      .idx     (idx),
      .load    (load),
      .err     (dec_err)
   );

   always_comb begin
      bus_d = src == SRC_G   ? G
            : src == SRC_DIN ? DIN
            : src == SRC_REG ? regs_q[idx]
            : bus_q;
      valid_d = load;
      // A fresh error outranks a simultaneous clear.
      err_d = dec_err | (err_q & ~ClrErr);
      // Registers load the pre-edge bus, which makes same-cycle read/write a swap.
      regs_d = regs_q;
      for (int i = 0; i < N_REGS; i++)
         if (Rin[i]) regs_d[i] = bus_q;
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         regs_q  <= '0;
         bus_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         regs_q  <= regs_d;
         bus_q   <= bus_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign BusWires = bus_q;
   assign BusValid = valid_q;
   assign SelErr   = err_q;
   assign RegFlat  = regs_q;

endmodule

// File: tb/tb_reg_bus_mux.sv
// tb_reg_bus_mux: directed checks of a one-hot 8-register instance and an encoded 6-register instance.
module tb_reg_bus_mux;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic [15:0]  a_din, a_g, a_bus;
   logic         a_gout, a_dinout, a_rsel_en, a_clr, a_valid, a_err;
   logic [7:0]   a_rout, a_rin;
   logic [2:0]   a_rsel;
   logic [127:0] a_flat;

   logic [15:0]  b_din, b_g, b_bus;
   logic         b_gout, b_dinout, b_rsel_en, b_clr, b_valid, b_err;
   logic [5:0]   b_rout, b_rin;
   logic [2:0]   b_rsel;
   logic [95:0]  b_flat;

   int n_chk = 0;
   int n_bad = 0;

   reg_bus_mux #(.WIDTH(16), .N_REGS(8), .SEL_ENCODED(1'b0)) dut_a (
      .Clock(clk), .Reset(rst), .DIN(a_din), .G(a_g), .Gout(a_gout), .DINout(a_dinout),
      .Rout(a_rout), .RSel(a_rsel), .RSelEn(a_rsel_en), .Rin(a_rin), .ClrErr(a_clr),
      .BusWires(a_bus), .BusValid(a_valid), .SelErr(a_err), .RegFlat(a_flat)
   );

   reg_bus_mux #(.WIDTH(16), .N_REGS(6), .SEL_ENCODED(1'b1)) dut_b (
      .Clock(clk), .Reset(rst), .DIN(b_din), .G(b_g), .Gout(b_gout), .DINout(b_dinout),
      .Rout(b_rout), .RSel(b_rsel), .RSelEn(b_rsel_en), .Rin(b_rin), .ClrErr(b_clr),
      .BusWires(b_bus), .BusValid(b_valid), .SelErr(b_err), .RegFlat(b_flat)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      a_gout = 0; a_dinout = 0; a_rout = '0; a_rin = '0; a_clr = 0; a_rsel_en = 0;
      b_gout = 0; b_dinout = 0; b_rout = '0; b_rin = '0; b_clr = 0; b_rsel_en = 0;
   endtask

   initial begin
      a_din = '0; a_g = '0; a_rsel = '0;
      b_din = '0; b_g = '0; b_rsel = '0;
      idle();
      rst = 1;
      step();
      step();
      rst = 0;
      chk("rst_bus", a_bus, 0);
      chk("rst_valid", a_valid, 0);
      chk("rst_err", a_err, 0);
      chk("rst_regs", a_flat, 0);
      chk("rst_b_regs", b_flat, 0);

      a_dinout = 1; a_din = 16'hA5A5;
      step();
      chk("din_bus", a_bus, 16'hA5A5);
      chk("din_valid", a_valid, 1);
      idle();
      step();
      chk("hold_bus", a_bus, 16'hA5A5);
      chk("hold_valid", a_valid, 0);

      a_dinout = 1; a_din = 16'h1234;
      step();
      idle(); a_rin = 8'b0000_0100;
      step();
      chk("reg2_load", a_flat[32 +: 16], 16'h1234);
      chk("reg2_only", a_flat & ~(128'hFFFF << 32), 0);
      idle(); a_rout = 8'b0000_0100;
      step();
      chk("reg2_read", a_bus, 16'h1234);
      chk("reg2_read_valid", a_valid, 1);
      chk("no_err", a_err, 0);

      idle(); a_gout = 1; a_dinout = 1; a_g = 16'h00FF; a_din = 16'hFF00;
      step();
      chk("conf_bus", a_bus, 16'h00FF);
      chk("conf_err", a_err, 1);
      idle();
      step();
      chk("err_sticky", a_err, 1);
      a_clr = 1;
      step();
      chk("err_clr", a_err, 0);
      a_gout = 1; a_dinout = 1;
      step();
      chk("clr_vs_new", a_err, 1);
      idle(); a_clr = 1;
      step();
      chk("err_clr2", a_err, 0);

      idle(); a_rout = 8'b0010_0100;
      step();
      chk("multi_rout_bus", a_bus, 16'h1234);
      chk("multi_rout_err", a_err, 1);
      idle(); a_clr = 1;
      step();

      idle(); a_dinout = 1; a_din = 16'h0003;
      step();
      idle(); a_rin = 8'b0000_1000;
      step();
      idle(); a_dinout = 1; a_din = 16'h0099;
      step();
      idle(); a_rout = 8'b0000_1000; a_rin = 8'b0000_1000;
      step();
      chk("rw_bus", a_bus, 16'h0003);
      chk("rw_reg3", a_flat[48 +: 16], 16'h0099);
      chk("rw_err", a_err, 0);
      idle(); a_rin = 8'b1000_0001;
      step();
      chk("bcast_r0", a_flat[0 +: 16], 16'h0003);
      chk("bcast_r7", a_flat[112 +: 16], 16'h0003);
      chk("bcast_r3", a_flat[48 +: 16], 16'h0099);

      idle(); a_rout = 8'b0000_0001; a_dinout = 1; a_din = 16'h7777;
      step();
      chk("din_over_reg", a_bus, 16'h7777);
      chk("din_reg_err", a_err, 1);

      idle(); b_dinout = 1; b_din = 16'h5555;
      step();
      idle(); b_rin = 6'b10_0000;
      step();
      chk("b_reg5", b_flat[80 +: 16], 16'h5555);
      idle(); b_dinout = 1; b_din = 16'h0000;
      step();
      idle(); b_rsel = 3'd5; b_rsel_en = 1;
      step();
      chk("b_sel5_bus", b_bus, 16'h5555);
      chk("b_sel5_valid", b_valid, 1);
      chk("b_sel5_err", b_err, 0);
      idle(); b_rsel = 3'd5; b_rout = 6'b11_1111;
      step();
      chk("b_noen_valid", b_valid, 0);
      chk("b_rout_ignored_err", b_err, 0);
      idle(); b_rsel = 3'd7; b_rsel_en = 1;
      step();
      chk("b_oor_bus", b_bus, 16'h5555);
      chk("b_oor_valid", b_valid, 0);
      chk("b_oor_err", b_err, 1);

      idle(); a_dinout = 1; a_din = 16'hBEEF;
      rst = 1;
      step();
      rst = 0;
      chk("midrst_bus", a_bus, 0);
      chk("midrst_valid", a_valid, 0);
      chk("midrst_regs", a_flat, 0);
      chk("midrst_err", a_err, 0);
      chk("midrst_b_err", b_err, 0);
      step();
      chk("post_rst_bus", a_bus, 16'hBEEF);
      chk("post_rst_valid", a_valid, 1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
